// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared data-memory port between instruction fetch and load/store.
// Optional busy-timeout abort is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int LS_PRIORITY    = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   input  logic [3:0]  ls_rmask,
   input  logic [3:0]  ls_wmask,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_mask,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        owner,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   logic [31:0] rdata_q;
   logic        any_req;
   logic        pick_ls;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   // On a tie, owner doubles as the round-robin pointer: the last owner loses.
   always_comb begin
      any_req = if_req | ls_req;
      if (if_req && ls_req) pick_ls = (LS_PRIORITY != 0) ? 1'b1 : ~owner;
      else                  pick_ls = ls_req;
   end

   assign if_gnt    = rst_n && (state == IDLE) && if_req && !pick_ls;
   assign ls_gnt    = rst_n && (state == IDLE) && pick_ls;
   assign busy      = (state != IDLE);
   assign mem_req   = (state == BUSY);
   assign if_rvalid = (state == DONE) && !owner;
   assign ls_rvalid = (state == DONE) && owner;
   assign if_rdata  = rdata_q;
   assign ls_rdata  = rdata_q;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] tmo_cnt;
   logic       err_q;
   assign timeout_err = err_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         mem_mask  <= 4'h0;
         rdata_q   <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
         tmo_cnt   <= 8'h0;
         err_q     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state <= BUSY;
                  owner <= pick_ls;
                  if (pick_ls) begin
                     mem_we    <= ls_we;
                     mem_addr  <= ls_addr;
                     mem_wdata <= ls_wdata;
                     mem_mask  <= ls_we ? ls_wmask : ls_rmask;
                  end else begin
                     mem_we    <= 1'b0;
                     mem_addr  <= if_addr;
                     mem_wdata <= 32'h0;
                     mem_mask  <= 4'hF;
                  end
`ifdef MEM_ARB_TIMEOUT_EN
                  tmo_cnt <= 8'h0;
`endif
               end
            end
            // An ack on the limit cycle takes precedence over the timeout.
            BUSY: begin
               if (mem_ack) begin
                  rdata_q <= mem_we ? 32'h0 : mem_rdata;
                  state   <= DONE;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  rdata_q <= 32'h0;
                  err_q   <= 1'b1;
                  state   <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
`endif
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (LS priority and round-robin) share one stimulus stream
// and are compared every cycle against a timestamp-based transaction model.
module tb_mem_port_arbiter;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        ls_req = 1'b0;
   logic        ls_we = 1'b0;
   logic [31:0] ls_addr = '0;
   logic [31:0] ls_wdata = '0;
   logic [3:0]  ls_rmask = '0;
   logic [3:0]  ls_wmask = '0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   logic        if_gnt_o [2];
   logic        if_rvalid_o [2];
   logic [31:0] if_rdata_o [2];
   logic        ls_gnt_o [2];
   logic        ls_rvalid_o [2];
   logic [31:0] ls_rdata_o [2];
   logic        mem_req_o [2];
   logic        mem_we_o [2];
   logic [31:0] mem_addr_o [2];
   logic [31:0] mem_wdata_o [2];
   logic [3:0]  mem_mask_o [2];
   logic        busy_o [2];
   logic        owner_o [2];
   logic        timeout_err_o [2];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.LS_PRIORITY(1), .TIMEOUT_CYCLES(TMO)) u_dut_pri (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_o[0]),
      .if_rvalid(if_rvalid_o[0]), .if_rdata(if_rdata_o[0]),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_rmask(ls_rmask), .ls_wmask(ls_wmask), .ls_gnt(ls_gnt_o[0]),
      .ls_rvalid(ls_rvalid_o[0]), .ls_rdata(ls_rdata_o[0]),
      .mem_req(mem_req_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
      .mem_wdata(mem_wdata_o[0]), .mem_mask(mem_mask_o[0]),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .busy(busy_o[0]), .owner(owner_o[0]), .timeout_err(timeout_err_o[0])
   );

   mem_port_arbiter #(.LS_PRIORITY(0), .TIMEOUT_CYCLES(TMO)) u_dut_rr (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_o[1]),
      .if_rvalid(if_rvalid_o[1]), .if_rdata(if_rdata_o[1]),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_rmask(ls_rmask), .ls_wmask(ls_wmask), .ls_gnt(ls_gnt_o[1]),
      .ls_rvalid(ls_rvalid_o[1]), .ls_rdata(ls_rdata_o[1]),
      .mem_req(mem_req_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
      .mem_wdata(mem_wdata_o[1]), .mem_mask(mem_mask_o[1]),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .busy(busy_o[1]), .owner(owner_o[1]), .timeout_err(timeout_err_o[1])
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: each transaction is a grant cycle plus an end cycle (ack or timeout).
   // BUSY spans (grant, end], DONE is end+1, the port is free again from end+2.
   int          cyc = 0;
   bit          m_lsprio [2] = '{1'b1, 1'b0};
   bit          m_have [2];
   int          m_g [2];
   int          m_e [2];
   bit          m_own [2];
   bit          m_we [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_wdata [2];
   logic [3:0]  m_mask [2];
   logic [31:0] m_rdata [2];
   bit          m_err [2];

   task automatic modelStep(input int d);
      bit want_ls, e_if_gnt, e_ls_gnt, e_req, e_done;
      string p;
      p = $sformatf("d%0d ", d);
      if (!rst_n) begin
         m_have[d] = 0; m_own[d] = 0; m_err[d] = 0; m_rdata[d] = '0;
         checkOutput({p, "rst if_gnt"}, if_gnt_o[d], 0);
         checkOutput({p, "rst ls_gnt"}, ls_gnt_o[d], 0);
         checkOutput({p, "rst busy"}, busy_o[d], 0);
         checkOutput({p, "rst mem_req"}, mem_req_o[d], 0);
         checkOutput({p, "rst if_rvalid"}, if_rvalid_o[d], 0);
         checkOutput({p, "rst ls_rvalid"}, ls_rvalid_o[d], 0);
         checkOutput({p, "rst owner"}, owner_o[d], 0);
         checkOutput({p, "rst timeout_err"}, timeout_err_o[d], 0);
         checkOutput({p, "rst mem_addr"}, mem_addr_o[d], 0);
         checkOutput({p, "rst mem_mask"}, 32'(mem_mask_o[d]), 0);
         checkOutput({p, "rst if_rdata"}, if_rdata_o[d], 0);
         return;
      end
      if (m_have[d] && m_e[d] >= 0 && cyc >= m_e[d] + 2) m_have[d] = 0;
      want_ls  = ls_req && (!if_req || m_lsprio[d] || !m_own[d]);
      e_ls_gnt = !m_have[d] && want_ls;
      e_if_gnt = !m_have[d] && if_req && !want_ls;
      e_req    = m_have[d] && m_e[d] < 0 && cyc > m_g[d];
      e_done   = m_have[d] && m_e[d] >= 0 && cyc == m_e[d] + 1;
      checkOutput({p, "if_gnt"}, if_gnt_o[d], e_if_gnt);
      checkOutput({p, "ls_gnt"}, ls_gnt_o[d], e_ls_gnt);
      checkOutput({p, "busy"}, busy_o[d], m_have[d]);
      checkOutput({p, "mem_req"}, mem_req_o[d], e_req);
      checkOutput({p, "owner"}, owner_o[d], m_own[d]);
      checkOutput({p, "timeout_err"}, timeout_err_o[d], m_err[d]);
      checkOutput({p, "if_rvalid"}, if_rvalid_o[d], e_done && !m_own[d]);
      checkOutput({p, "ls_rvalid"}, ls_rvalid_o[d], e_done && m_own[d]);
      if (e_req) begin
         checkOutput({p, "mem_we"}, mem_we_o[d], m_we[d]);
         checkOutput({p, "mem_addr"}, mem_addr_o[d], m_addr[d]);
         checkOutput({p, "mem_wdata"}, mem_wdata_o[d], m_wdata[d]);
         checkOutput({p, "mem_mask"}, 32'(mem_mask_o[d]), 32'(m_mask[d]));
      end
      if (e_done) begin
         if (m_own[d]) checkOutput({p, "ls_rdata"}, ls_rdata_o[d], m_rdata[d]);
         else          checkOutput({p, "if_rdata"}, if_rdata_o[d], m_rdata[d]);
      end
      if (e_if_gnt || e_ls_gnt) begin
         m_have[d] = 1; m_g[d] = cyc; m_e[d] = -1; m_own[d] = e_ls_gnt;
         m_we[d]    = e_ls_gnt ? ls_we : 1'b0;
         m_addr[d]  = e_ls_gnt ? ls_addr : if_addr;
         m_wdata[d] = e_ls_gnt ? ls_wdata : 32'h0;
         m_mask[d]  = e_ls_gnt ? (ls_we ? ls_wmask : ls_rmask) : 4'hF;
      end else if (e_req) begin
         if (mem_ack) begin
            m_e[d] = cyc;
            m_rdata[d] = m_we[d] ? 32'h0 : mem_rdata;
         end
`ifdef MEM_ARB_TIMEOUT_EN
         else if (cyc - m_g[d] == TMO) begin
            m_e[d] = cyc; m_rdata[d] = 32'h0; m_err[d] = 1;
         end
`endif
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         for (int d = 0; d < 2; d++) modelStep(d);
      end
   end

   task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic lsr,
                                input logic we, input logic [31:0] la, input logic [31:0] wd,
                                input logic [3:0] rm, input logic [3:0] wm,
                                input logic ack, input logic [31:0] rd);
      @(posedge clk);
      #1;
      if_req = ifr; if_addr = ifa; ls_req = lsr; ls_we = we; ls_addr = la;
      ls_wdata = wd; ls_rmask = rm; ls_wmask = wm; mem_ack = ack; mem_rdata = rd;
      @(negedge clk);
   endtask

   task automatic idleCycle(input logic ack, input logic [31:0] rd);
      applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 4'h0, ack, rd);
   endtask

   task automatic fetchGrant(input logic [31:0] a);
      applyStimulus(1, a, 0, 0, 32'h0, 32'h0, 4'h0, 4'h0, 0, 32'h0);
      for (int d = 0; d < 2; d++) checkOutput($sformatf("d%0d fetch grant", d), if_gnt_o[d], 1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit seen;
      int stall;
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);

      // Three back-to-back ties straight out of reset.
      for (int k = 0; k < 9; k++) begin
         applyStimulus(k < 7, 32'h200, k < 7, 0, 32'h300, 32'h0, 4'b0001, 4'h0, 1, 32'hA5A5_0000 + k);
         if (k % 3 == 0) begin
            checkOutput("tie pri ls_gnt", ls_gnt_o[0], 1);
            checkOutput("tie pri if_gnt", if_gnt_o[0], 0);
            checkOutput("tie rr ls_gnt", ls_gnt_o[1], (k == 3) ? 0 : 1);
            checkOutput("tie rr if_gnt", if_gnt_o[1], (k == 3) ? 1 : 0);
         end
      end
      idleCycle(0, 32'h0);

      // Lone fetch, ack one cycle after mem_req.
      fetchGrant(32'h0000_0040);
      idleCycle(0, 32'h0);
      checkOutput("fetch mem_addr", mem_addr_o[0], 32'h40);
      checkOutput("fetch mem_mask", 32'(mem_mask_o[0]), 32'hF);
      checkOutput("fetch mem_we", mem_we_o[0], 0);
      idleCycle(1, 32'h2402_0005);
      idleCycle(0, 32'h0BAD_0BAD);
      checkOutput("fetch if_rvalid", if_rvalid_o[0], 1);
      checkOutput("fetch if_rdata", if_rdata_o[0], 32'h2402_0005);
      idleCycle(0, 32'h0);
      checkOutput("fetch busy back to 0", busy_o[0], 0);

      // Store with ack on the fourth BUSY cycle.
      applyStimulus(0, 32'h0, 1, 1, 32'h100, 32'hDEAD_BEEF, 4'b1111, 4'b0011, 0, 32'h0);
      checkOutput("store ls_gnt", ls_gnt_o[0], 1);
      for (int k = 1; k <= 4; k++) begin
         idleCycle(k == 4, 32'h55AA_55AA);
         checkOutput("store mem_req", mem_req_o[0], 1);
         checkOutput("store mem_we", mem_we_o[0], 1);
         checkOutput("store mem_mask", 32'(mem_mask_o[0]), 32'h3);
         checkOutput("store mem_wdata", mem_wdata_o[0], 32'hDEAD_BEEF);
      end
      idleCycle(0, 32'h0);
      checkOutput("store ls_rvalid", ls_rvalid_o[0], 1);
      checkOutput("store ls_rdata", ls_rdata_o[0], 32'h0);
      idleCycle(0, 32'h0);
      checkOutput("store ls_rvalid single", ls_rvalid_o[0], 0);

      // Ack on the limit cycle: data returned, no error.
      fetchGrant(32'h0000_0060);
      for (int k = 1; k <= TMO; k++) begin
         idleCycle(k == TMO, 32'h1357_9BDF);
         checkOutput("limit mem_req", mem_req_o[0], 1);
      end
      idleCycle(0, 32'h0);
      checkOutput("limit if_rvalid", if_rvalid_o[0], 1);
      checkOutput("limit if_rdata", if_rdata_o[0], 32'h1357_9BDF);
      checkOutput("limit timeout_err", timeout_err_o[0], 0);

      // Memory never acks.
      fetchGrant(32'h0000_0080);
      for (int k = 1; k <= TMO; k++) begin
         idleCycle(0, 32'hFFFF_FFFF);
         checkOutput("stall mem_req", mem_req_o[0], 1);
      end
`ifdef MEM_ARB_TIMEOUT_EN
      idleCycle(0, 32'hFFFF_FFFF);
      checkOutput("timeout mem_req dropped", mem_req_o[0], 0);
      checkOutput("timeout if_rvalid", if_rvalid_o[0], 1);
      checkOutput("timeout if_rdata", if_rdata_o[0], 32'h0);
      checkOutput("timeout err set", timeout_err_o[0], 1);
      fetchGrant(32'h0000_0084);
      idleCycle(1, 32'h0000_1111);
      idleCycle(0, 32'h0);
      checkOutput("after timeout if_rdata", if_rdata_o[0], 32'h0000_1111);
      checkOutput("timeout err sticky", timeout_err_o[0], 1);
`else
      idleCycle(0, 32'hFFFF_FFFF);
      checkOutput("no timeout mem_req held", mem_req_o[0], 1);
      idleCycle(1, 32'h0000_2222);
      idleCycle(0, 32'h0);
      checkOutput("late ack if_rdata", if_rdata_o[0], 32'h0000_2222);
      checkOutput("timeout_err tied", timeout_err_o[0], 0);
`endif
      idleCycle(0, 32'h0);

      // Randomized traffic, with occasional long ack stalls.
      stall = 0;
      for (int k = 0; k < 400; k++) begin
         if (stall == 0 && $urandom_range(0, 39) == 0) stall = 12;
         if (stall > 0) stall--;
         applyStimulus($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                       $urandom, $urandom, 4'($urandom), 4'($urandom),
                       (stall == 0) && ($urandom_range(0, 9) < 4), $urandom);
      end
      idleCycle(1, 32'h0);
      idleCycle(1, 32'h0);
      idleCycle(0, 32'h0);

      // Reset asserted mid-BUSY, then a normal fetch once released.
      fetchGrant(32'h0000_0400);
      idleCycle(0, 32'h0);
      checkOutput("pre-reset mem_req", mem_req_o[0], 1);
      @(posedge clk);
      #2 rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0404; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      #1;
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("d%0d async reset mem_req", d), mem_req_o[d], 0);
         checkOutput($sformatf("d%0d async reset busy", d), busy_o[d], 0);
      end
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (if_rvalid_o[0]) seen = 1;
         else applyStimulus(if_req && !if_gnt_o[0], 32'h0000_0404, 0, 0, 32'h0, 32'h0, 4'h0, 4'h0,
                            1, 32'hCAFE_F00D);
      end
      checkOutput("post-reset fetch completes", seen, 1);
      checkOutput("post-reset if_rdata", if_rdata_o[0], 32'hCAFE_F00D);
      idleCycle(0, 32'h0);
      idleCycle(0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
